// File: rtl/dsdmnist_pkg.sv
// Shared types and constants for the N-lane multiply-accumulate block.
// Holds the FSM state encoding, the beat-to-valid latency and the shift-field width.
package dsdmnist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam int LATENCY = 4;
  localparam int SHIFT_W = 5;

endpackage

// File: rtl/dsdmnist_addtree.sv
// Registered signed reduction of LANES product terms into one lane sum.
// The valid flag travels with the registered sum.
module dsdmnist_addtree
  import dsdmnist_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IW    = 16,
  parameter int OW    = IW + $clog2(LANES)
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_vld,
  input  logic signed [IW-1:0] i_terms [LANES],
  output logic signed [OW-1:0] o_sum,
  output logic                 o_vld
);

  logic signed [OW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + OW'(i_terms[i]);
    end
  end

  // stage p1: lane sum
  always_ff @(posedge i_CLK) begin
    if (i_vld) o_sum <= w_sum;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) o_vld <= 1'b0;
    else       o_vld <= i_vld;
  end

endmodule

// File: rtl/dsdmnist_nlane_macc.sv
// N-lane signed dot-product engine: multiply, reduce, accumulate, then
// requantise (bias, arithmetic shift, optional ReLU, saturation) into one result.
module dsdmnist_nlane_macc
  import dsdmnist_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int OPW    = 8,
  parameter int ACCW   = 32,
  parameter int LENW   = 10,
  parameter     USEDSP = "no"
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_START,
  input  logic [LENW-1:0]        i_LEN,
  input  logic signed [ACCW-1:0] i_BIAS,
  input  logic [SHIFT_W-1:0]     i_SHIFT,
  input  logic                   i_RELU,
  input  logic                   i_VALID,
  output logic                   o_READY,
  input  logic signed [OPW-1:0]  i_OPSET0 [0:LANES-1],
  input  logic signed [OPW-1:0]  i_OPSET1 [0:LANES-1],
  output logic                   o_VALID,
  input  logic                   i_OUT_READY,
  output logic signed [OPW-1:0]  o_RESULT,
  output logic signed [ACCW-1:0] o_ACC,
  output logic                   o_BUSY
);

  localparam int PW = 2 * OPW;
  localparam int SW = PW + $clog2(LANES);
  localparam logic signed [ACCW:0] RMAX = (ACCW+1)'((2 ** (OPW - 1)) - 1);
  localparam logic signed [ACCW:0] RMIN = ~RMAX;

  state_t                  r_state;
  logic [LENW-1:0]         r_len;
  logic [LENW-1:0]         r_cnt;
  logic signed [ACCW-1:0]  r_bias;
  logic [SHIFT_W-1:0]      r_shift;
  logic                    r_relu;
  (* use_dsp = USEDSP *)
  logic signed [PW-1:0]    r_prod_p0 [LANES];
  logic                    r_vld_p0;
  logic signed [SW-1:0]    w_sum_p1;
  logic                    w_vld_p1;
  (* use_dsp = USEDSP *)
  logic signed [ACCW-1:0]  r_acc_p2;
  logic                    r_drained;
  logic signed [OPW-1:0]   r_result;
  logic                    w_start;
  logic                    w_beat;
  logic                    w_last;

  function automatic logic signed [OPW-1:0] sat(input logic signed [ACCW:0] v);
    if (v > RMAX)      return RMAX[OPW-1:0];
    else if (v < RMIN) return RMIN[OPW-1:0];
    else               return v[OPW-1:0];
  endfunction

  // acc + bias is formed one bit wider so the sum itself never wraps
  function automatic logic signed [OPW-1:0] requant(input logic signed [ACCW-1:0] acc,
                                                    input logic signed [ACCW-1:0] bias,
                                                    input logic [SHIFT_W-1:0] sh,
                                                    input logic relu);
    logic signed [ACCW:0] v;
    v = {acc[ACCW-1], acc} + {bias[ACCW-1], bias};
    v = v >>> sh;
    if (relu && v[ACCW]) v = '0;
    return sat(v);
  endfunction

  assign w_start = (r_state == S_IDLE) && i_START;
  assign w_beat  = i_VALID && o_READY;
  assign w_last  = w_beat && (r_cnt == r_len - 1'b1);

  always_ff @(posedge i_CLK) begin
    if (w_start) begin
      r_len   <= i_LEN;
      r_bias  <= i_BIAS;
      r_shift <= i_SHIFT;
      r_relu  <= i_RELU;
    end
  end

  // stage p0: per-lane products
  always_ff @(posedge i_CLK) begin
    if (w_beat) begin
      for (int i = 0; i < LANES; i++) begin
        r_prod_p0[i] <= i_OPSET0[i] * i_OPSET1[i];
      end
    end
  end

  dsdmnist_addtree #(
    .LANES (LANES),
    .IW    (PW),
    .OW    (SW)
  ) u_addtree (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_vld   (r_vld_p0),
    .i_terms (r_prod_p0),
    .o_sum   (w_sum_p1),
    .o_vld   (w_vld_p1)
  );

  // stage p2: accumulator; r_drained rises one cycle after p0/p1 have emptied in DRAIN
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_vld_p0  <= 1'b0;
      r_drained <= 1'b0;
      r_acc_p2  <= '0;
      r_result  <= '0;
    end else begin
      r_vld_p0  <= w_beat;
      r_drained <= (r_state == S_DRAIN) && !r_vld_p0 && !w_vld_p1;
      if (w_start)       r_acc_p2 <= '0;
      else if (w_vld_p1) r_acc_p2 <= r_acc_p2 + ACCW'(w_sum_p1);
      case (r_state)
        S_IDLE: begin
          if (i_START) begin
            r_cnt   <= '0;
            r_state <= (i_LEN == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drained) begin
            r_state  <= S_OUT;
            r_result <= requant(r_acc_p2, r_bias, r_shift, r_relu);
          end
        end
        S_OUT: begin
          if (i_OUT_READY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_READY  = (r_state == S_RUN);
  assign o_VALID  = (r_state == S_OUT);
  assign o_BUSY   = (r_state != S_IDLE);
  assign o_RESULT = r_result;
  assign o_ACC    = r_acc_p2;

endmodule

// File: doc/dsdmnist_nlane_macc.md
DSDMNIST_NLANE_MACC -- requirements
Module: dsdmnist_nlane_macc

Interface
REQ-001 Parameter LANES, default 4: parallel multiply lanes per beat, a power of two, minimum 2.
REQ-002 Parameter OPW, default 8: signed operand width.
REQ-003 Parameter ACCW, default 32: signed accumulator width.
REQ-004 Parameter LENW, default 10: width of the beat-count field.
REQ-005 Parameter USEDSP, default "no": value of the use_dsp attribute on the multiplier registers.
REQ-006 i_CLK  in  1  single clock, all logic on the rising edge.
REQ-007 i_RST  in  1  reset, synchronous, active-high.
REQ-008 i_START  in  1  begin a new dot product; sampled in IDLE only.
REQ-009 i_LEN  in  LENW  number of beats; latched on start.
REQ-010 i_BIAS  in  ACCW  signed bias; latched on start.
REQ-011 i_SHIFT  in  5  arithmetic right-shift amount; latched on start.
REQ-012 i_RELU  in  1  clamp negative results to 0; latched on start.
REQ-013 i_VALID  in  1  operand beat valid.
REQ-014 o_READY  out  1  beat accepted when i_VALID and o_READY are both high.
REQ-015 i_OPSET0, i_OPSET1  in  [0:LANES-1] x OPW  signed operand vectors.
REQ-016 o_VALID  out  1  result valid; held until accepted.
REQ-017 i_OUT_READY  in  1  result accepted when o_VALID and i_OUT_READY are both high.
REQ-018 o_RESULT  out  OPW  signed requantised result.
REQ-019 o_ACC  out  ACCW  raw accumulator value, before bias.
REQ-020 o_BUSY  out  1  high in every state except IDLE.

Function
REQ-021 FSM states and transitions:
- IDLE: on i_START go to RUN; if i_LEN=0, go to DRAIN instead.
- RUN: on acceptance of beat i_LEN, go to DRAIN.
- DRAIN: when the pipeline is empty, go to OUT.
- OUT: on output handshake, go to IDLE.
REQ-022 o_READY SHALL be high only in RUN.
REQ-023 Stage 1: LANES products, each 2*OPW bits, registered.
REQ-024 Stage 2: sum of all lanes at width 2*OPW+log2(LANES), registered; no overflow is possible at this width.
REQ-025 Stage 3: accumulator adds the lane sum, sign-extended to ACCW.
- Cleared to 0 on the start edge.
- Overflow wraps in two's complement.
REQ-026 Stage 4: output register, loaded once on entry to OUT:
- r = (acc + bias) >>> shift, arithmetic.
- If RELU and r < 0, then r = 0.
- r saturates to [-2^(OPW-1), 2^(OPW-1)-1].
REQ-027 Latency: o_VALID SHALL rise exactly 4 cycles after the clock edge that accepts the last beat, regardless of any gaps between beats.
REQ-028 Valid bubbles (i_VALID low in RUN) SHALL NOT contribute to the accumulator and SHALL NOT count toward i_LEN.
REQ-029 o_RESULT and o_ACC SHALL be stable while o_VALID is high and i_OUT_READY is low.
REQ-030 i_START outside IDLE SHALL be ignored; latched parameters are unchanged.
REQ-031 i_LEN=0: result is the requantised bias alone; o_VALID rises 2 cycles after the start edge.
REQ-032 An output handshake and i_START in the same cycle SHALL NOT start a new run; the new run starts from IDLE on a later cycle.

Reset
REQ-033 While i_RST is high, the following SHALL apply on the next edge:
- State goes to IDLE.
- o_VALID=0, o_READY=0, o_BUSY=0, o_RESULT=0, o_ACC=0.
- Pipeline valid flags and the beat counter are cleared.
REQ-034 Reset during RUN, DRAIN or OUT aborts the run with no partial result emitted; i_RST has priority over all other inputs.

Structure
REQ-035 Package dsdmnist_pkg SHALL hold:
- The FSM state enum.
- The latency constant (4).
- The shift-field width (5).
REQ-036 One sub-module, dsdmnist_addtree, SHALL perform the registered LANES-input signed reduction; it is instantiated once.
REQ-037 The multiply and accumulate registers SHALL carry the use_dsp attribute set to USEDSP.

Verification
REQ-038 Basic: LANES=4, LEN=2, beats {1,2,3,4}.{1,1,1,1} and {-1,-1,-1,-1}.{2,2,2,2}, bias 0, shift 0 -> o_ACC=2, o_RESULT=2, o_VALID 4 cycles after beat 2.
REQ-039 Saturation and ReLU:
- All operands 127, LEN=4 -> o_ACC=258064; o_RESULT=127 at shift 0, 126 at shift 11.
- Operands 127 and -128, RELU=1 -> o_RESULT=0.
REQ-040 Bubbles and backpressure: random i_VALID gaps, i_OUT_READY held low 10 cycles -> result identical to the gapless run; o_RESULT stable throughout; o_READY low in DRAIN and OUT.
REQ-041 Zero length: LEN=0, bias -300, shift 1 -> o_RESULT=-128, o_ACC=0.
REQ-042 Reset mid-run: i_RST asserted after beat 3 of 8, then a fresh LEN=1 run with {1,1,1,1}.{1,1,1,1} -> exactly one o_VALID, o_ACC=4.
